// File: rtl/alu_share_arb.sv
// Two requesters share one NZCV-producing ALU through a round-robin arbiter.
// Results land in a one-entry response slot; each requester keeps its own flag register.

module alu_nzcv #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   ctrl,
  output logic [N-1:0] result,
  output logic [3:0]   nzcv
);

  logic         is_sub;
  logic [N-1:0] b_op;
  logic [N:0]   sum;
  logic         carry;
  logic         ovf;

  assign is_sub = (ctrl == 2'b01);
  assign b_op   = is_sub ? ~b : b;
  // Subtract as a + ~b + 1 so carry-out reads as "no borrow".
  assign sum    = {1'b0, a} + {1'b0, b_op} + {{N{1'b0}}, is_sub};
  assign ovf    = (a[N-1] == b_op[N-1]) && (sum[N-1] != a[N-1]);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (ctrl)
      2'b00, 2'b01: begin
        result = sum[N-1:0];
        carry  = sum[N];
      end
      2'b10:   result = a & b;
      default: result = a | b;
    endcase
  end

  always_comb begin
    nzcv[3] = result[N-1];
    nzcv[2] = (result == '0);
    nzcv[1] = ctrl[1] ? 1'b0 : carry;
    nzcv[0] = ctrl[1] ? 1'b0 : ovf;
  end

endmodule

module alu_share_arb #(
  parameter int unsigned N = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [1:0]   i_req_valid,
  output logic [1:0]   o_req_ready,
  input  logic [N-1:0] i_a0,
  input  logic [N-1:0] i_b0,
  input  logic [1:0]   i_ctrl0,
  input  logic         i_setf0,
  input  logic [N-1:0] i_a1,
  input  logic [N-1:0] i_b1,
  input  logic [1:0]   i_ctrl1,
  input  logic         i_setf1,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic         o_rsp_id,
  output logic [N-1:0] o_result,
  output logic [3:0]   o_nzcv,
  output logic [3:0]   o_flags0,
  output logic [3:0]   o_flags1
);

  logic         grant;
  logic         last_grant;
  logic         slot_free;
  logic         accept;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;
  logic [1:0]   sel_ctrl;
  logic         sel_setf;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;

  assign slot_free = !o_rsp_valid || i_rsp_ready;

  always_comb begin
    grant = 1'b0;
    case (i_req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    if (slot_free) o_req_ready[grant] = i_req_valid[grant];
  end

  assign accept = |o_req_ready;

  always_comb begin
    sel_a    = grant ? i_a1    : i_a0;
    sel_b    = grant ? i_b1    : i_b0;
    sel_ctrl = grant ? i_ctrl1 : i_ctrl0;
    sel_setf = grant ? i_setf1 : i_setf0;
  end

  alu_nzcv #(.N(N)) u_alu (
    .a      (sel_a),
    .b      (sel_b),
    .ctrl   (sel_ctrl),
    .result (alu_result),
    .nzcv   (alu_flags)
  );

  // Pointer starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= 1'b0;
      o_result    <= '0;
      o_nzcv      <= '0;
      o_flags0    <= '0;
      o_flags1    <= '0;
      last_grant  <= 1'b1;
    end else begin
      if (accept) begin
        o_rsp_valid <= 1'b1;
        o_rsp_id    <= grant;
        o_result    <= alu_result;
        o_nzcv      <= alu_flags;
        last_grant  <= grant;
        if (sel_setf) begin
          if (grant) o_flags1 <= alu_flags;
          else       o_flags0 <= alu_flags;
        end
      end else if (i_rsp_ready) begin
        o_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: a negedge monitor models arbitration, slot and flags;
// scenario tasks add directed checks on the documented corner cases.

module tb_alu_share_arb;

  localparam int unsigned N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] a0, b0, a1, b1;
  logic [1:0]   ctrl0, ctrl1;
  logic         setf0, setf1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] result;
  logic [3:0]   nzcv;
  logic [3:0]   flags0, flags1;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic         mon_en  = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_ptr   = 1'b1;
  logic [3:0]   m_flags0 = '0;
  logic [3:0]   m_flags1 = '0;
  logic [68:0]  sb[$];

  always #5 clk = ~clk;

  alu_share_arb #(.N(N)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_a0        (a0),
    .i_b0        (b0),
    .i_ctrl0     (ctrl0),
    .i_setf0     (setf0),
    .i_a1        (a1),
    .i_b1        (b1),
    .i_ctrl1     (ctrl1),
    .i_setf1     (setf1),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_result    (result),
    .o_nzcv      (nzcv),
    .o_flags0    (flags0),
    .o_flags1    (flags1)
  );

  // Reference ALU: returns {nzcv, result}; overflow taken from a sign-extended wide sum.
  function automatic logic [67:0] model_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [1:0] ctrl);
    logic [N:0]        w;
    logic signed [N:0] s;
    logic [N-1:0]      r;
    logic              c, v;
    w = '0; s = '0; c = 1'b0; v = 1'b0;
    case (ctrl)
      2'b00: begin
        w = {1'b0, a} + {1'b0, b};
        s = $signed({a[N-1], a}) + $signed({b[N-1], b});
        r = w[N-1:0]; c = w[N]; v = s[N] ^ s[N-1];
      end
      2'b01: begin
        w = {1'b0, a} + {1'b0, ~b} + 65'd1;
        s = $signed({a[N-1], a}) - $signed({b[N-1], b});
        r = w[N-1:0]; c = w[N]; v = s[N] ^ s[N-1];
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[N-1], (r == '0), c, v, r};
  endfunction

  always @(negedge clk) begin
    logic        g;
    logic        free_m;
    logic [1:0]  exp_rdy;
    logic [67:0] m;
    if (mon_en) begin
      vectors++;
      if (rsp_valid !== m_valid) begin
        errors++; $display("FAIL sb_rsp_valid: got %b expected %b", rsp_valid, m_valid);
      end
      vectors++;
      if (flags0 !== m_flags0 || flags1 !== m_flags1) begin
        errors++;
        $display("FAIL sb_flags: got %b/%b expected %b/%b", flags0, flags1, m_flags0, m_flags1);
      end
      free_m = !m_valid || rsp_ready;
      case (req_valid)
        2'b10:   g = 1'b1;
        2'b11:   g = ~m_ptr;
        default: g = 1'b0;
      endcase
      exp_rdy = '0;
      if (free_m && req_valid[g]) exp_rdy[g] = 1'b1;
      vectors++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL sb_req_ready: got %b expected %b", req_ready, exp_rdy);
      end
      if (m_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL sb_empty: got valid response expected none queued");
        end else if ({rsp_id, nzcv, result} !== sb[0]) begin
          errors++;
          $display("FAIL sb_rsp: got id=%b nzcv=%b res=%h expected id=%b nzcv=%b res=%h",
                   rsp_id, nzcv, result, sb[0][68], sb[0][67:64], sb[0][63:0]);
        end
      end
      if (reset) begin
        m_valid = 1'b0; m_ptr = 1'b1; m_flags0 = '0; m_flags1 = '0;
        sb.delete();
      end else begin
        if (m_valid && rsp_ready && sb.size() > 0) void'(sb.pop_front());
        if (exp_rdy != 2'b00) begin
          m = g ? model_alu(a1, b1, ctrl1) : model_alu(a0, b0, ctrl0);
          sb.push_back({g, m});
          if (g && setf1)        m_flags1 = m[67:64];
          else if (!g && setf0)  m_flags0 = m[67:64];
          m_ptr   = g;
          m_valid = 1'b1;
        end else if (rsp_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 2'b00; rsp_ready = 1'b0;
    a0 = '0; b0 = '0; ctrl0 = 2'b00; setf0 = 1'b0;
    a1 = '0; b1 = '0; ctrl1 = 2'b00; setf1 = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_id, nzcv, flags0, flags1} !== 14'd0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b id=%b res=%h nzcv=%b f0=%b f1=%b expected all zero",
               rsp_valid, rsp_id, result, nzcv, flags0, flags1);
    end
    req_valid = 2'b11; #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL reset_first_grant: got %b expected 01", req_ready);
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_flags();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b01; a0 = 64'd5; b0 = 64'd5; ctrl0 = 2'b01; setf0 = 1'b1;
    step();
    vectors++;
    if ({rsp_valid, rsp_id, nzcv, flags0, flags1} !== {1'b1, 1'b0, 4'b0110, 4'b0110, 4'b0000}
        || result !== 64'd0) begin
      errors++;
      $display("FAIL sub_equal: got v=%b id=%b res=%h nzcv=%b f0=%b f1=%b expected 1 0 0 0110 0110 0000",
               rsp_valid, rsp_id, result, nzcv, flags0, flags1);
    end
    req_valid = 2'b10; a1 = 64'h7FFF_FFFF_FFFF_FFFF; b1 = 64'd1; ctrl1 = 2'b00; setf1 = 1'b1;
    step();
    vectors++;
    if (rsp_id !== 1'b1 || result !== 64'h8000_0000_0000_0000 || nzcv !== 4'b1001 ||
        flags1 !== 4'b1001 || flags0 !== 4'b0110) begin
      errors++;
      $display("FAIL add_overflow: got id=%b res=%h nzcv=%b f0=%b f1=%b expected 1 8000000000000000 1001 0110 1001",
               rsp_id, result, nzcv, flags0, flags1);
    end
    a1 = 64'h8000_0000_0000_0000; b1 = 64'h8000_0000_0000_0000; ctrl1 = 2'b10; setf1 = 1'b0;
    step();
    vectors++;
    if (result !== 64'h8000_0000_0000_0000 || nzcv !== 4'b1000 || flags1 !== 4'b1001) begin
      errors++;
      $display("FAIL and_nosetf: got res=%h nzcv=%b f1=%b expected 8000000000000000 1000 1001",
               result, nzcv, flags1);
    end
    a1 = 64'h0000_0000_0000_00F0; b1 = 64'h0000_0000_0000_000F; ctrl1 = 2'b11; setf1 = 1'b1;
    step();
    vectors++;
    if (result !== 64'h0000_0000_0000_00FF || nzcv !== 4'b0000 || flags1 !== 4'b0000) begin
      errors++;
      $display("FAIL or_setf: got res=%h nzcv=%b f1=%b expected 00000000000000ff 0000 0000",
               result, nzcv, flags1);
    end
    idle(); rsp_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    rsp_ready = 1'b1; req_valid = 2'b11;
    a0 = 64'd100; b0 = 64'd1; ctrl0 = 2'b00; setf0 = 1'b1;
    a1 = 64'd2;   b1 = 64'd9; ctrl1 = 2'b01; setf1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL alt_grant[%0d]: got %b expected %b", i, req_ready,
                           (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      step();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2)) begin
        errors++; $display("FAIL alt_rsp[%0d]: got v=%b id=%b expected 1 %0d", i, rsp_valid, rsp_id, i % 2);
      end
      a0 = a0 + 64'd3; b1 = b1 - 64'd4;
    end
    idle(); rsp_ready = 1'b1;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 2'b11;
    a0 = 64'd3;  b0 = 64'd4;  ctrl0 = 2'b00; setf0 = 1'b0;
    a1 = 64'hF0; b1 = 64'h3C; ctrl1 = 2'b10; setf1 = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== 1'b0 ||
          result !== 64'd7 || nzcv !== 4'b0000) begin
        errors++;
        $display("FAIL stall[%0d]: got rdy=%b v=%b id=%b res=%h nzcv=%b expected 00 1 0 7 0000",
                 i, req_ready, rsp_valid, rsp_id, result, nzcv);
      end
      step();
    end
    rsp_ready = 1'b1; #1;
    vectors++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL stall_release: got %b expected 10", req_ready);
    end
    step();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || result !== 64'h30) begin
      errors++; $display("FAIL stall_refill: got v=%b id=%b res=%h expected 1 1 30",
                         rsp_valid, rsp_id, result);
    end
    idle(); rsp_ready = 1'b1;
    step();
  endtask

  task automatic test_drop();
    do_reset();
    req_valid = 2'b01; a0 = 64'd1; b0 = 64'd1; ctrl0 = 2'b00; setf0 = 1'b0;
    step();
    req_valid = 2'b10; a1 = 64'd1; b1 = 64'd2; ctrl1 = 2'b01; setf1 = 1'b1;
    step(); step();
    req_valid = 2'b01; a0 = 64'd10; b0 = 64'd20; ctrl0 = 2'b01; setf0 = 1'b1;
    rsp_ready = 1'b1; #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL drop_grant: got %b expected 01", req_ready);
    end
    step();
    vectors++;
    if (rsp_id !== 1'b0 || result !== 64'hFFFF_FFFF_FFFF_FFF6 || flags0 !== 4'b1000 ||
        flags1 !== 4'b0000) begin
      errors++;
      $display("FAIL drop_result: got id=%b res=%h f0=%b f1=%b expected 0 fffffffffffffff6 1000 0000",
               rsp_id, result, flags0, flags1);
    end
    req_valid = 2'b00;
    step();
    vectors++;
    if (rsp_valid !== 1'b0 || flags1 !== 4'b0000) begin
      errors++; $display("FAIL drop_drain: got v=%b f1=%b expected 0 0000", rsp_valid, flags1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b01; a0 = 64'd3; b0 = 64'd5; ctrl0 = 2'b01; setf0 = 1'b1;
    step();
    vectors++;
    if (flags0 !== 4'b1000) begin
      errors++; $display("FAIL pre_reset_flags: got %b expected 1000", flags0);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || flags0 !== 4'b0000 || flags1 !== 4'b0000) begin
      errors++; $display("FAIL reset_mid: got v=%b f0=%b f1=%b expected 0 0000 0000",
                         rsp_valid, flags0, flags1);
    end
    req_valid = 2'b11; a1 = 64'd8; b1 = 64'd8; ctrl1 = 2'b00; setf1 = 1'b0; #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL reset_mid_grant: got %b expected 01", req_ready);
    end
    step();
    vectors++;
    if (rsp_id !== 1'b0) begin
      errors++; $display("FAIL reset_mid_id: got %b expected 0", rsp_id);
    end
    idle(); rsp_ready = 1'b1;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_flags();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Shares a single alu_nzcv instance between two requesters. Arbitration is round-robin and each request uses a valid/ready handshake. The result and NZCV are held in a one-entry registered response slot tagged with the requester ID. Each requester has its own architectural NZCV flag register, written only on flag-setting operations; both flag registers feed the two issue stages' condition logic.

Parameters:
N, 64, datapath width of operands and result (N >= 2)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_req_valid  input  2  bit k: requester k presents an operation
o_req_ready  output  2  bit k: requester k's operation is accepted this cycle
i_a0, i_b0  input  N each  requester 0 operands
i_ctrl0  input  2  requester 0 ALU op: 00 add, 01 sub, 10 and, 11 or
i_setf0  input  1  requester 0 op updates flags0
i_a1, i_b1, i_ctrl1, i_setf1  input  N, N, 2, 1  requester 1 equivalents
o_rsp_valid  output  1  response slot holds a result
i_rsp_ready  input  1  consumer takes the response this cycle
o_rsp_id  output  1  requester that issued the held result
o_result  output  N  held ALU result
o_nzcv  output  4  held NZCV of that op: bit3 N, bit2 Z, bit1 C, bit0 V
o_flags0, o_flags1  output  4 each  architectural NZCV per requester

Behaviour:
- Reset values: o_rsp_valid=0, o_rsp_id=0, o_result=0, o_nzcv=0, o_flags0=o_flags1=0. The last-grant pointer is set to 1 so requester 0 wins the first contention.
- Reset has priority over every other event. Reset mid-operation discards the held response and any acceptance in that cycle; flags clear.
- Slot free: free = !o_rsp_valid | i_rsp_ready. Draining and refilling in the same cycle is allowed, giving full throughput.
- Grant (combinational):
  - Only 0 valid -> grant 0. Only 1 valid -> grant 1.
  - Both valid -> grant the requester that is not the last-granted one.
  - o_req_ready[k] = free & i_req_valid[k] & (grant==k). At most one bit is set.
- Ready does not depend on ready being seen first. Requesters hold operands, ctrl and setf stable while valid is high and ready is low. Dropping valid before acceptance is allowed; the dropped op is never executed.
- Datapath:
  - The selected requester's operands and ctrl drive the single ALU instance combinationally.
  - On acceptance the ALU result and NZCV are registered into the slot, o_rsp_id is set to grant, o_rsp_valid is set, and the last-grant pointer is updated.
  - Latency: accept at edge T, response visible from T+1.
- Response hold: while o_rsp_valid & !i_rsp_ready, the slot is frozen and o_req_ready=00. If i_rsp_ready is high with no acceptance, o_rsp_valid clears. The data fields keep their stale values.
- Flags:
  - On acceptance with setf of the granted requester = 1, o_flags[grant] takes the ALU NZCV at the same edge the slot loads. The other requester's flags are unchanged.
  - Flag update does not wait for the response to be consumed.
- NZCV rules:
  - Z = result all-zero. N = result[N-1].
  - For add/sub: C = adder carry-out, with sub computed as a + ~b + 1, so C=1 means no borrow. V = signed overflow.
  - For and/or: C=0, V=0.
- Arithmetic wraps modulo 2^N.
- The pointer updates only on acceptance, not on mere request.

Test Plan:
- Reset, then requester 0 sub with a=5, b=5, setf0=1, i_rsp_ready=1 -> next cycle o_rsp_valid=1, id=0, result=0, o_nzcv=0110, o_flags0=0110, o_flags1=0000.
- Requester 1 add with a=0x7FFF_FFFF_FFFF_FFFF, b=1, setf1=1 -> result=0x8000_0000_0000_0000, o_nzcv=1001, o_flags1=1001. Repeat with and, a=b=0x8000_0000_0000_0000 -> o_nzcv=1000, and o_flags1 is unchanged when setf1=0.
- Both valid continuously from reset with i_rsp_ready=1 -> grants alternate 0,1,0,1 on consecutive cycles and o_rsp_id follows the same sequence one cycle later, with no bubbles.
- Backpressure: i_rsp_ready=0 for 3 cycles with a response held and both requesting -> o_req_ready=00, slot fields constant. Raise i_rsp_ready -> acceptance in the same cycle, and the new result is visible the next cycle.
- Requester 1 drops valid while stalled, then requester 0 requests -> requester 1's op is never executed and o_flags1 is unchanged.
- Assert i_reset in the cycle a request is accepted -> next cycle o_rsp_valid=0 and flags 0000. The first contention after reset grants requester 0.
